// File: rtl/ysyx_22040386_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
package ysyx_22040386_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned MASK_W = XLEN / 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/ysyx_22040386_arb_prio.sv
// Combinational grant: MEM has priority unless IF has been passed over
// STARVE_LIMIT times in a row while waiting.
module ysyx_22040386_arb_prio
  import ysyx_22040386_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic             if_valid,
  input  logic             mem_valid,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_if,
  output logic             grant_mem
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  always_comb begin
    grant_mem = mem_valid && !(if_valid && (starve_cnt == LIMIT));
    grant_if  = if_valid && !grant_mem;
  end

endmodule

// File: rtl/ysyx_22040386_mem_arbiter.sv
// Shares one memory bus between IF fetch and MEM load/store, one
// transaction outstanding, responses routed back to the owner.
module ysyx_22040386_mem_arbiter
  import ysyx_22040386_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              i_ARB_clk,
  input  logic              i_ARB_rst,
  input  logic              i_if_req_valid,
  output logic              o_if_req_ready,
  input  logic [XLEN-1:0]   i_if_addr,
  output logic              o_if_rsp_valid,
  output logic [XLEN-1:0]   o_if_rsp_data,
  input  logic              i_mem_req_valid,
  output logic              o_mem_req_ready,
  input  logic              i_mem_req_wen,
  input  logic [XLEN-1:0]   i_mem_addr,
  input  logic [XLEN-1:0]   i_mem_wdata,
  input  logic [MASK_W-1:0] i_mem_wmask,
  output logic              o_mem_rsp_valid,
  output logic [XLEN-1:0]   o_mem_rsp_data,
  output logic              o_bus_req_valid,
  input  logic              i_bus_req_ready,
  output logic              o_bus_req_wen,
  output logic [XLEN-1:0]   o_bus_addr,
  output logic [XLEN-1:0]   o_bus_wdata,
  output logic [MASK_W-1:0] o_bus_wmask,
  input  logic              i_bus_rsp_valid,
  input  logic [XLEN-1:0]   i_bus_rsp_data,
  output logic              o_busy
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  arb_owner_e       owner_q;
  logic [CNT_W-1:0] starve_cnt, starve_d;
  logic             gnt_if_raw, gnt_mem_raw;
  logic             accept_if, accept_mem;
  logic             rsp_fire;

  ysyx_22040386_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .if_valid  (i_if_req_valid),
    .mem_valid (i_mem_req_valid),
    .starve_cnt(starve_cnt),
    .grant_if  (gnt_if_raw),
    .grant_mem (gnt_mem_raw)
  );

  // Readies are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    accept_if  = (state_q == IDLE) && !i_ARB_rst && gnt_if_raw;
    accept_mem = (state_q == IDLE) && !i_ARB_rst && gnt_mem_raw;
    rsp_fire   = (state_q == WAIT) && i_bus_rsp_valid;
    state_d    = state_q;
    starve_d   = starve_cnt;

    case (state_q)
      IDLE:    if (accept_if || accept_mem) state_d = ISSUE;
      ISSUE:   if (i_bus_req_ready)         state_d = WAIT;
      WAIT:    if (i_bus_rsp_valid)         state_d = IDLE;
      default:                              state_d = IDLE;
    endcase

    if (accept_if) begin
      starve_d = '0;
    end else if (accept_mem) begin
      if (!i_if_req_valid)        starve_d = '0;
      else if (starve_cnt != LIMIT) starve_d = starve_cnt + 1'b1;
    end
  end

  assign o_if_req_ready  = accept_if;
  assign o_mem_req_ready = accept_mem;
  assign o_bus_req_valid = (state_q == ISSUE);
  assign o_busy          = (state_q != IDLE);

  always_ff @(posedge i_ARB_clk or posedge i_ARB_rst) begin
    if (i_ARB_rst) begin
      state_q    <= IDLE;
      starve_cnt <= '0;
    end else begin
      state_q    <= state_d;
      starve_cnt <= starve_d;
    end
  end

  always_ff @(posedge i_ARB_clk or posedge i_ARB_rst) begin
    if (i_ARB_rst) begin
      owner_q         <= OWN_IF;
      o_bus_req_wen   <= 1'b0;
      o_bus_addr      <= '0;
      o_bus_wdata     <= '0;
      o_bus_wmask     <= '0;
      o_if_rsp_valid  <= 1'b0;
      o_if_rsp_data   <= '0;
      o_mem_rsp_valid <= 1'b0;
      o_mem_rsp_data  <= '0;
    end else begin
      o_if_rsp_valid  <= rsp_fire && (owner_q == OWN_IF);
      o_mem_rsp_valid <= rsp_fire && (owner_q == OWN_MEM);

      if (rsp_fire) begin
        if (owner_q == OWN_IF) o_if_rsp_data  <= i_bus_rsp_data;
        else                   o_mem_rsp_data <= o_bus_req_wen ? '0 : i_bus_rsp_data;
      end

      if (accept_mem) begin
        owner_q       <= OWN_MEM;
        o_bus_req_wen <= i_mem_req_wen;
        o_bus_addr    <= i_mem_addr;
        o_bus_wdata   <= i_mem_wdata;
        o_bus_wmask   <= i_mem_req_wen ? i_mem_wmask : '0;
      end else if (accept_if) begin
        owner_q       <= OWN_IF;
        o_bus_req_wen <= 1'b0;
        o_bus_addr    <= i_if_addr;
        o_bus_wdata   <= '0;
        o_bus_wmask   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040386_mem_arbiter.sv
// Directed and randomized checks of the IF/MEM arbiter against a
// transaction-level reference model.
module tb_ysyx_22040386_mem_arbiter;

  localparam int STARVE_LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_if_req_valid = 1'b0;
  logic        o_if_req_ready;
  logic [63:0] i_if_addr = '0;
  logic        o_if_rsp_valid;
  logic [63:0] o_if_rsp_data;
  logic        i_mem_req_valid = 1'b0;
  logic        o_mem_req_ready;
  logic        i_mem_req_wen = 1'b0;
  logic [63:0] i_mem_addr = '0;
  logic [63:0] i_mem_wdata = '0;
  logic [7:0]  i_mem_wmask = '0;
  logic        o_mem_rsp_valid;
  logic [63:0] o_mem_rsp_data;
  logic        o_bus_req_valid;
  logic        i_bus_req_ready = 1'b0;
  logic        o_bus_req_wen;
  logic [63:0] o_bus_addr;
  logic [63:0] o_bus_wdata;
  logic [7:0]  o_bus_wmask;
  logic        i_bus_rsp_valid = 1'b0;
  logic [63:0] i_bus_rsp_data = '0;
  logic        o_busy;

  always #5 clk = ~clk;

  ysyx_22040386_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_ARB_clk      (clk),
    .i_ARB_rst      (rst),
    .i_if_req_valid (i_if_req_valid),
    .o_if_req_ready (o_if_req_ready),
    .i_if_addr      (i_if_addr),
    .o_if_rsp_valid (o_if_rsp_valid),
    .o_if_rsp_data  (o_if_rsp_data),
    .i_mem_req_valid(i_mem_req_valid),
    .o_mem_req_ready(o_mem_req_ready),
    .i_mem_req_wen  (i_mem_req_wen),
    .i_mem_addr     (i_mem_addr),
    .i_mem_wdata    (i_mem_wdata),
    .i_mem_wmask    (i_mem_wmask),
    .o_mem_rsp_valid(o_mem_rsp_valid),
    .o_mem_rsp_data (o_mem_rsp_data),
    .o_bus_req_valid(o_bus_req_valid),
    .i_bus_req_ready(i_bus_req_ready),
    .o_bus_req_wen  (o_bus_req_wen),
    .o_bus_addr     (o_bus_addr),
    .o_bus_wdata    (o_bus_wdata),
    .o_bus_wmask    (o_bus_wmask),
    .i_bus_rsp_valid(i_bus_rsp_valid),
    .i_bus_rsp_data (i_bus_rsp_data),
    .o_busy         (o_busy)
  );

  int    errors = 0;
  int    checks = 0;
  string glog = "";

  // Transaction-level model: one outstanding access, accepted-by-bus flag.
  logic        m_out, m_acc, m_owner_mem, m_wen;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  int          m_starve;
  logic        m_if_rv, m_mem_rv;
  logic [63:0] m_if_rd, m_mem_rd;
  logic        last_eg_if, last_eg_mem;

  task automatic model_reset();
    m_out = 0; m_acc = 0; m_owner_mem = 0; m_wen = 0;
    m_addr = '0; m_wdata = '0; m_wmask = '0; m_starve = 0;
    m_if_rv = 0; m_mem_rv = 0; m_if_rd = '0; m_mem_rd = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input string exp);
    checks++;
    assert (glog == exp) else begin
      errors++;
      $error("FAIL %s: observed=%s expected=%s", tag, glog, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_rdy"},  o_if_req_ready, 0);
    chk({tag, "_mem_rdy"}, o_mem_req_ready, 0);
    chk({tag, "_if_rv"},   o_if_rsp_valid, 0);
    chk({tag, "_if_rd"},   o_if_rsp_data, 0);
    chk({tag, "_mem_rv"},  o_mem_rsp_valid, 0);
    chk({tag, "_mem_rd"},  o_mem_rsp_data, 0);
    chk({tag, "_bus_v"},   o_bus_req_valid, 0);
    chk({tag, "_bus_wen"}, o_bus_req_wen, 0);
    chk({tag, "_bus_a"},   o_bus_addr, 0);
    chk({tag, "_bus_wd"},  o_bus_wdata, 0);
    chk({tag, "_bus_wm"},  o_bus_wmask, 0);
    chk({tag, "_busy"},    o_busy, 0);
  endtask

  // Called at posedge+1; drives one cycle, checks it, advances the model.
  task automatic step(input logic if_v, input logic [63:0] if_a,
                      input logic mem_v, input logic wen, input logic [63:0] ma,
                      input logic [63:0] wd, input logic [7:0] wm,
                      input logic bready, input logic rv, input logic [63:0] rd);
    logic eg_if, eg_mem, nif, nmem;
    i_if_req_valid = if_v;  i_if_addr = if_a;
    i_mem_req_valid = mem_v; i_mem_req_wen = wen; i_mem_addr = ma;
    i_mem_wdata = wd; i_mem_wmask = wm;
    i_bus_req_ready = bready; i_bus_rsp_valid = rv; i_bus_rsp_data = rd;
    #1;
    eg_if = 0; eg_mem = 0;
    if (!m_out) begin
      if (if_v && mem_v) begin
        eg_mem = (m_starve != STARVE_LIMIT);
        eg_if  = !eg_mem;
      end else begin
        eg_if = if_v; eg_mem = mem_v;
      end
    end
    chk("if_ready",  o_if_req_ready, eg_if);
    chk("mem_ready", o_mem_req_ready, eg_mem);
    chk("bus_valid", o_bus_req_valid, m_out && !m_acc);
    chk("busy",      o_busy, m_out);
    chk("bus_wen",   o_bus_req_wen, m_wen);
    chk("bus_addr",  o_bus_addr, m_addr);
    chk("bus_wdata", o_bus_wdata, m_wdata);
    chk("bus_wmask", o_bus_wmask, m_wmask);
    chk("if_rsp_v",  o_if_rsp_valid, m_if_rv);
    chk("if_rsp_d",  o_if_rsp_data, m_if_rd);
    chk("mem_rsp_v", o_mem_rsp_valid, m_mem_rv);
    chk("mem_rsp_d", o_mem_rsp_data, m_mem_rd);
    if (o_if_req_ready)  glog = {glog, "I"};
    if (o_mem_req_ready) glog = {glog, "M"};
    last_eg_if = eg_if; last_eg_mem = eg_mem;

    nif = 0; nmem = 0;
    if (m_out && m_acc && rv) begin
      if (m_owner_mem) begin nmem = 1; m_mem_rd = m_wen ? 64'd0 : rd; end
      else             begin nif = 1;  m_if_rd = rd; end
      m_out = 0;
    end else if (m_out && !m_acc && bready) begin
      m_acc = 1;
    end else if (eg_mem) begin
      m_out = 1; m_acc = 0; m_owner_mem = 1; m_wen = wen;
      m_addr = ma; m_wdata = wd; m_wmask = wen ? wm : 8'h00;
      m_starve = if_v ? ((m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1) : 0;
    end else if (eg_if) begin
      m_out = 1; m_acc = 0; m_owner_mem = 0; m_wen = 0;
      m_addr = if_a; m_wdata = '0; m_wmask = '0; m_starve = 0;
    end
    m_if_rv = nif; m_mem_rv = nmem;
    @(posedge clk); #1;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic        if_pend, mem_pend, mwen;
  logic [63:0] ia, ma, mwd;
  logic [7:0]  mwm;

  initial begin
    model_reset();
    #1;
    chk_all_zero("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Lone IF fetch: response at T+2, pulse at T+3.
    step(1, 64'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0000_0013_0000_0297);
    chk("t1_if_rsp_v", o_if_rsp_valid, 1);
    chk("t1_if_rsp_d", o_if_rsp_data, 64'h0000_0013_0000_0297);
    chk("t1_mem_rsp_v", o_mem_rsp_valid, 0);
    idle_step();

    // Simultaneous IF + MEM store: MEM first, IF in the next IDLE.
    glog = "";
    step(1, 64'h8000_0004, 1, 1, 64'h8000_1008, 64'hDEAD_BEEF, 8'h0F, 0, 0, 0);
    chk("t2_bus_wen", o_bus_req_wen, 1);
    chk("t2_bus_wmask", o_bus_wmask, 8'h0F);
    chk("t2_bus_addr", o_bus_addr, 64'h8000_1008);
    step(1, 64'h8000_0004, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 64'h8000_0004, 0, 0, 0, 0, 0, 0, 1, 64'h1111_2222_3333_4444);
    chk("t2_mem_rsp_v", o_mem_rsp_valid, 1);
    chk("t2_mem_rsp_d", o_mem_rsp_data, 0);
    step(1, 64'h8000_0004, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h5555_6666_7777_8888);
    chk_log("t2_order", "MI");
    idle_step();

    // Starvation guard with both requesters continuously valid.
    glog = "";
    for (int i = 0; i < 24; i++) begin
      step(1, 64'h8000_0100, 1, 0, 64'h8000_3000, 0, 8'hFF, 1, 1, {$urandom, $urandom});
      if (i == 11) chk("t3_starve_clr", dut.starve_cnt, 0);
    end
    chk_log("t3_order", "MMMIMMMI");
    idle_step();

    // Bus stall in ISSUE: fields stable, no readies.
    step(1, 64'h8000_2000, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 64'h8000_2008, 1, 1, 64'h8000_9000, 64'h77, 8'hFF, 0, 0, 0);
      chk("t4_addr", o_bus_addr, 64'h8000_2000);
      chk("t4_wdata", o_bus_wdata, 0);
      chk("t4_wmask", o_bus_wmask, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'hABCD);
    idle_step();

    // Spurious response during ISSUE is dropped; real one delivered once.
    step(1, 64'h8000_4000, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0BAD);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h0BAD2);
    chk("t5_no_spurious", o_if_rsp_valid, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h1234_5678_9ABC_DEF0);
    chk("t5_rsp_v", o_if_rsp_valid, 1);
    chk("t5_rsp_d", o_if_rsp_data, 64'h1234_5678_9ABC_DEF0);
    idle_step();
    chk("t5_once", o_if_rsp_valid, 0);

    // Reset asserted mid-WAIT with starve_cnt nonzero.
    step(1, 64'h8000_6000, 1, 0, 64'h8000_5000, 0, 0, 0, 0, 0);
    step(1, 64'h8000_6000, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t6_busy_wait", o_busy, 1);
    i_if_req_valid = 1; i_mem_req_valid = 1;
    #2 rst = 1'b1;
    #1;
    chk_all_zero("t6_async");
    i_if_req_valid = 0; i_mem_req_valid = 0;
    @(posedge clk); #1;
    chk_all_zero("t6_held");
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("t6_starve", dut.starve_cnt, 0);
    chk("t6_busy", o_busy, 0);
    glog = "";
    step(1, 64'h8000_7000, 0, 0, 0, 0, 0, 1, 0, 0);
    chk_log("t6_first_grant", "I");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h42);
    idle_step();

    // Randomized traffic against the model.
    if_pend = 0; mem_pend = 0;
    ia = '0; ma = '0; mwd = '0; mwm = '0; mwen = 0;
    for (int i = 0; i < 400; i++) begin
      if (!if_pend && ($urandom % 4 != 0)) begin
        if_pend = 1; ia = {32'h0, $urandom} & ~64'h7;
      end else if (if_pend && ($urandom % 16 == 0)) begin
        if_pend = 0;
      end
      if (!mem_pend && ($urandom % 3 != 0)) begin
        mem_pend = 1; mwen = 1'($urandom);
        ma = {$urandom, $urandom}; mwd = {$urandom, $urandom}; mwm = 8'($urandom);
      end
      step(if_pend, ia, mem_pend, mwen, ma, mwd, mwm,
           1'($urandom % 2), 1'($urandom % 5 < 2), {$urandom, $urandom});
      if (last_eg_if)  if_pend = 0;
      if (last_eg_mem) mem_pend = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22040386_mem_arbiter.md
# ysyx_22040386_mem_arbiter

Two-requester memory-port arbiter and sequencer for the pipelined core. Shares a single memory bus (DPI-C pmem bridge or SoC memory) between the IF-stage instruction fetch and the MEM-stage load/store unit. It holds one transaction outstanding at a time and routes each response back to its owner. MEM has priority, with a starvation guard that guarantees IF forward progress.

## Interface
- STARVE_LIMIT, 3: consecutive MEM grants taken while IF is waiting before IF is forced a grant; legal range 1..15.
- i_ARB_clk  in  1  clock; all state on the rising edge.
- i_ARB_rst  in  1  reset; asynchronous, active-high.
- i_if_req_valid  in  1  IF fetch request.
- o_if_req_ready  out  1  IF request accepted this cycle.
- i_if_addr  in  64  fetch address.
- o_if_rsp_valid  out  1  one-cycle pulse; fetch data valid.
- o_if_rsp_data  out  64  fetched doubleword.
- i_mem_req_valid  in  1  MEM request.
- o_mem_req_ready  out  1  MEM request accepted this cycle.
- i_mem_req_wen  in  1  1 = store, 0 = load.
- i_mem_addr  in  64  access address (ALU result).
- i_mem_wdata  in  64  store data, already forwarded.
- i_mem_wmask  in  8  store byte mask.
- o_mem_rsp_valid  out  1  one-cycle pulse; load data valid or store acknowledged.
- o_mem_rsp_data  out  64  raw load doubleword; 0 for stores.
- o_bus_req_valid  out  1  bus request.
- i_bus_req_ready  in  1  bus accepts request.
- o_bus_req_wen, o_bus_addr, o_bus_wdata, o_bus_wmask  out  1/64/64/8  latched request fields.
- i_bus_rsp_valid  in  1  bus response; also returned for writes.
- i_bus_rsp_data  in  64  bus read data.
- o_busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: grant is combinational. Exactly one of o_if_req_ready / o_mem_req_ready may be high, and only toward a valid requester.
  - MEM wins when both requesters are valid, unless starve_cnt == STARVE_LIMIT; then IF wins.
- On handshake:
  - Latch wen, addr, wdata and wmask. For IF, wen = 0, wdata = 0 and wmask = 0; for MEM loads, wmask = 0 on the bus.
  - Latch the owner bit; go to ISSUE.
- ISSUE: o_bus_req_valid = 1 with the latched fields held stable. On i_bus_req_ready, go to WAIT.
- WAIT: on i_bus_rsp_valid, register the response into the owner's rsp_data and pulse the owner's rsp_valid for one cycle; go to IDLE.
- i_bus_rsp_valid outside WAIT is a protocol violation: ignore it, with no output pulse.
- starve_cnt (4 bits):
  - +1 on a MEM grant while i_if_req_valid = 1.
  - Cleared on an IF grant.
  - Cleared on a MEM grant while i_if_req_valid = 0.
  - Saturates at STARVE_LIMIT.
- Requesters must hold valid and fields until their ready is seen. Dropping valid before a grant is allowed and is not tracked.
- Reset:
  - State goes to IDLE, starve_cnt to 0, and all outputs to 0 (rsp data registers included).
  - Any in-flight transaction is discarded.
  - The bus side is reset by the same signal.

## Timing
- Accept at cycle T. o_bus_req_valid is high from T+1.
- With i_bus_req_ready high at T+1, WAIT starts at T+2.
- A response at cycle R gives o_X_rsp_valid at R+1, and the FSM is in IDLE at R+1. A new grant is possible at R+1.
- Minimum turnaround: 3 cycles per access (zero-latency bus responding at T+2). Back-to-back throughput is one access per 3 cycles.
- Request ready is combinational from IDLE state, the request valids and starve_cnt. Every other output is registered.
- Simultaneous IF and MEM valid in IDLE resolves by the priority rule above, within that cycle.

## Structure
- Shared package `ysyx_22040386_pkg`:
  - State encoding localparams: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2.
  - Owner encoding: OWN_IF = 1'b0, OWN_MEM = 1'b1.
  - Bus width constants.
- One natural sub-module: `ysyx_22040386_arb_prio`, the combinational priority and starvation-grant logic (inputs: two valids, starve_cnt; outputs: two grants).
- The FSM, latch registers and response routing stay in the top module.

## Test plan
- Lone IF fetch, addr 0x8000_0000; bus ready at once, rsp at T+2 with data 0x0000_0013_0000_0297:
  - o_if_rsp_valid pulses at T+3 with that data.
  - o_mem_rsp_valid stays 0.
- IF and MEM valid together in IDLE, MEM a store (addr 0x8000_1008, wdata 0xDEAD_BEEF, wmask 0x0F):
  - MEM is granted first; the bus sees wen = 1, wmask 0x0F.
  - o_mem_rsp_data = 0.
  - IF is granted in the next IDLE.
- MEM and IF both continuously valid, STARVE_LIMIT = 3: grant order is MEM, MEM, MEM, IF, MEM… and starve_cnt returns to 0 after the IF grant.
- Bus stall: i_bus_req_ready low for 5 cycles in ISSUE. o_bus_addr, wdata and wmask stay constant, and neither requester ready rises.
- A spurious i_bus_rsp_valid during ISSUE produces no rsp pulse. The real response after WAIT is delivered once.
- i_ARB_rst asserted mid-WAIT:
  - All outputs are 0 immediately, asynchronously.
  - After release: IDLE, o_busy = 0, starve_cnt = 0, and a fresh IF request is granted on the first cycle.
